regfile_2r1w: RTL and testbench

Parametrised MIPS general-purpose register file with two read ports and one write port. Register 0 is hard-wired to zero. Same-cycle write-to-read forwarding and an optional registered read stage are selectable by parameter. It sits in the decode stage and replaces the fixed 32-entry, bit-sliced read selection with a generalised N:1, W-bit read mux per port.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mux_n.sv | 49 ++++
 rtl/regfile_2r1w.sv | 116 +++++++++++
 tb/tb_regfile_2r1w.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word and register-address types plus the
// default sizing used by the register file.
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 1 << REG_ADDR_W;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/mux_n.sv
// Parametrised N:1, W-bit multiplexer built recursively as a tree of 2:1
// stages. The top select bit chooses between the lower and upper halves.
// N must be a power of two and at least 2.
module mux_n #(
    parameter  int unsigned N  = 2,
    parameter  int unsigned W  = 1,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0][W-1:0] d,
    input  logic [SW-1:0]       s,
    output logic [W-1:0]        y
);

    if (N == 2) begin : gen_leaf
        // Final 2:1 stage.
        always_comb begin
            y = s[0] ? d[1] : d[0];
        end
    end else begin : gen_split
        localparam int unsigned H = N / 2;

        logic [W-1:0] y_lo;
        logic [W-1:0] y_hi;

        mux_n #(
            .N(H),
            .W(W)
        ) u_lo (
            .d(d[H-1:0]),
            .s(s[SW-2:0]),
            .y(y_lo)
        );

        mux_n #(
            .N(H),
            .W(W)
        ) u_hi (
            .d(d[N-1:H]),
            .s(s[SW-2:0]),
            .y(y_hi)
        );

        // Top select bit picks between the two half-trees.
        always_comb begin
            y = s[SW-1] ? y_hi : y_lo;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// MIPS general-purpose register file: two read ports, one write port.
// Entry 0 has no storage and always reads zero. Optional same-cycle
// write-to-read bypass and optional registered read outputs.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter  int unsigned WIDTH  = WORD_W,
    parameter  int unsigned DEPTH  = REG_COUNT,
    parameter  bit          BYPASS = 1'b1,
    parameter  bit          RD_REG = 1'b0,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [WIDTH-1:0]            mem_q [1:DEPTH-1];
    logic [DEPTH-1:1]            wr_en_d;
    logic [DEPTH-1:0][WIDTH-1:0] rf_flat;
    logic [WIDTH-1:0]            mux1_y;
    logic [WIDTH-1:0]            mux2_y;
    logic                        byp1;
    logic                        byp2;
    logic [WIDTH-1:0]            rd1_d;
    logic [WIDTH-1:0]            rd2_d;

    // Per-entry write enable; address 0 never matches, so writes to it vanish.
    always_comb begin
        wr_en_d = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            wr_en_d[i] = we && (wa == AW'(i));
        end
    end

    // Storage for entries 1..DEPTH-1, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (wr_en_d[i]) begin
                    mem_q[i] <= wd;
                end
            end
        end
    end

    // Present the array as a flat mux input with a constant-zero slot 0.
    always_comb begin
        rf_flat[0] = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            rf_flat[i] = mem_q[i];
        end
    end

    mux_n #(
        .N(DEPTH),
        .W(WIDTH)
    ) u_mux1 (
        .d(rf_flat),
        .s(ra1),
        .y(mux1_y)
    );

    mux_n #(
        .N(DEPTH),
        .W(WIDTH)
    ) u_mux2 (
        .d(rf_flat),
        .s(ra2),
        .y(mux2_y)
    );

    // Read value per port: zero override, then bypass, then array contents.
    // Bypass is gated off during reset so outputs read zero while it is high.
    always_comb begin
        byp1  = BYPASS && we && !reset && (wa == ra1);
        byp2  = BYPASS && we && !reset && (wa == ra2);
        rd1_d = (ra1 == ZERO_ADDR) ? '0 : (byp1 ? wd : mux1_y);
        rd2_d = (ra2 == ZERO_ADDR) ? '0 : (byp2 ? wd : mux2_y);
    end

    if (RD_REG) begin : gen_rd_reg
        logic [WIDTH-1:0] rd1_q;
        logic [WIDTH-1:0] rd2_q;

        // Registered read outputs, updated every cycle with no enable.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
            end
        end

        assign rd1 = rd1_q;
        assign rd2 = rd2_q;
    end else begin : gen_rd_comb
        assign rd1 = rd1_d;
        assign rd2 = rd2_d;
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Three 32x32 instances share inputs
// (bypass/combinational, no-bypass/combinational, bypass/registered) and a
// 16x8 instance covers a non-default geometry. Expected values are queued
// when stimulus is driven and popped when the output is sampled.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;

    logic        we_s;
    logic [2:0]  wa_s, ra1_s, ra2_s;
    logic [15:0] wd_s, rd1_s, rd2_s;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b1), .RD_REG(1'b0)) dut_a (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a));

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b0), .RD_REG(1'b0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b));

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .BYPASS(1'b1), .RD_REG(1'b1)) dut_c (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_c), .rd2(rd2_c));

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .RD_REG(1'b0)) dut_s (
        .clk(clk), .reset(reset), .we(we_s), .wa(wa_s), .wd(wd_s),
        .ra1(ra1_s), .ra2(ra2_s), .rd1(rd1_s), .rd2(rd2_s));

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        we_s = 1'b0; wa_s = '0; wd_s = '0; ra1_s = '0; ra2_s = '0;
        repeat (2) @(posedge clk);
        // Write attempt while reset is held: no bypass, no storage.
        @(negedge clk);
        we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D; ra1 = 5'd4; ra2 = 5'd4;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL rst_byp_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_a !== e) $display("FAIL rst_byp_rd2_a got=%h exp=%h", rd2_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_c !== e) $display("FAIL rst_rd1_c got=%h exp=%h", rd1_c, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL rst_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; reset = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL rst_write_ignored got=%h exp=%h", rd1_a, e); else pass_cnt++;
        // Every address on both ports reads zero.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(31 - i);
            for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd1_a !== e) $display("FAIL rst_all_rd1_a a=%0d got=%h exp=%h", i, rd1_a, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd2_a !== e) $display("FAIL rst_all_rd2_a a=%0d got=%h exp=%h", 31 - i, rd2_a, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd1_b !== e) $display("FAIL rst_all_rd1_b a=%0d got=%h exp=%h", i, rd1_b, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd2_b !== e) $display("FAIL rst_all_rd2_b a=%0d got=%h exp=%h", 31 - i, rd2_b, e); else pass_cnt++;
            @(posedge clk); #1;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd1_c !== e) $display("FAIL rst_all_rd1_c a=%0d got=%h exp=%h", i, rd1_c, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd2_c !== e) $display("FAIL rst_all_rd2_c a=%0d got=%h exp=%h", 31 - i, rd2_c, e); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        wr(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        ra1 = 5'd5; ra2 = 5'd5;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL mid_pre_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        exp_q.push_back(32'hDEAD_BEEF);
        @(posedge clk); #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL mid_pre_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
        // Assert reset between edges: outputs must clear with no clock.
        reset = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL mid_rst_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_b !== e) $display("FAIL mid_rst_rd1_b got=%h exp=%h", rd1_b, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL mid_rst_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL mid_post_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
    endtask

    task automatic test_write_read();
        wr(5'd7, 32'h1234_5678);
        @(negedge clk);
        ra1 = 5'd7; ra2 = 5'd7;
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h1234_5678);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL wr_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_a !== e) $display("FAIL wr_rd2_a got=%h exp=%h", rd2_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_b !== e) $display("FAIL wr_rd1_b got=%h exp=%h", rd1_b, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_b !== e) $display("FAIL wr_rd2_b got=%h exp=%h", rd2_b, e); else pass_cnt++;
        @(posedge clk); #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_c !== e) $display("FAIL wr_rd1_c got=%h exp=%h", rd1_c, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL wr_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd7;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1234_5678);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL zero_byp_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_b !== e) $display("FAIL zero_rd1_b got=%h exp=%h", rd1_b, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_a !== e) $display("FAIL zero_indep_rd2_a got=%h exp=%h", rd2_a, e); else pass_cnt++;
        exp_q.push_back(32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_c !== e) $display("FAIL zero_rd1_c got=%h exp=%h", rd1_c, e); else pass_cnt++;
        @(negedge clk);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL zero_after_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr(5'd9, 32'hAAAA_0000);
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'h0000_BBBB; ra1 = 5'd9; ra2 = 5'd7;
        exp_q.push_back(32'h0000_BBBB); exp_q.push_back(32'hAAAA_0000);
        exp_q.push_back(32'h1234_5678);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL byp_same_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_b !== e) $display("FAIL nobyp_same_rd1_b got=%h exp=%h", rd1_b, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_a !== e) $display("FAIL byp_other_rd2_a got=%h exp=%h", rd2_a, e); else pass_cnt++;
        exp_q.push_back(32'h0000_BBBB);
        @(posedge clk); #1;
        we = 1'b0;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_c !== e) $display("FAIL byp_reg_rd1_c got=%h exp=%h", rd1_c, e); else pass_cnt++;
        @(negedge clk);
        wd = 32'h0000_1234;
        exp_q.push_back(32'h0000_BBBB); exp_q.push_back(32'h0000_BBBB);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_b !== e) $display("FAIL nobyp_next_rd1_b got=%h exp=%h", rd1_b, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd1_a !== e) $display("FAIL byp_we_low_rd1_a got=%h exp=%h", rd1_a, e); else pass_cnt++;
    endtask

    task automatic test_rd_reg();
        @(negedge clk);
        ra2 = 5'd0;
        wr(5'd3, 32'h0000_0055);
        @(negedge clk);
        ra2 = 5'd3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0000_0055);
        #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL rdreg_hold_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_a !== e) $display("FAIL rdreg_comb_rd2_a got=%h exp=%h", rd2_a, e); else pass_cnt++;
        exp_q.push_back(32'h0000_0055);
        @(posedge clk); #1;
        e = exp_q.pop_front(); chk_cnt++;
        if (rd2_c !== e) $display("FAIL rdreg_late_rd2_c got=%h exp=%h", rd2_c, e); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = 1'b1; wa = 5'(10 + i); wd = 32'h1000_0000 + 32'(i);
            ra1 = 5'(10 + i); ra2 = 5'(9 + i);
            exp_q.push_back(32'h1000_0000 + 32'(i));
            exp_q.push_back(32'h0);
            exp_q.push_back((i == 0) ? 32'h0000_BBBB : 32'h1000_0000 + 32'(i - 1));
            #1;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd1_a !== e) $display("FAIL b2b_rd1_a i=%0d got=%h exp=%h", i, rd1_a, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd1_b !== e) $display("FAIL b2b_rd1_b i=%0d got=%h exp=%h", i, rd1_b, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if (rd2_b !== e) $display("FAIL b2b_rd2_b i=%0d got=%h exp=%h", i, rd2_b, e); else pass_cnt++;
            @(posedge clk);
        end
        #1;
        we = 1'b0;
    endtask

    task automatic test_small_config();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we_s = 1'b1; wa_s = 3'(i); wd_s = 16'(i * 32'h1111);
            @(posedge clk); #1;
        end
        we_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra1_s = 3'(i); ra2_s = 3'(7 - i);
            exp_q.push_back(32'(i * 32'h1111));
            exp_q.push_back(32'((7 - i) * 32'h1111));
            #1;
            e = exp_q.pop_front(); chk_cnt++;
            if ({16'h0, rd1_s} !== e) $display("FAIL small_rd1 a=%0d got=%h exp=%h", i, rd1_s, e); else pass_cnt++;
            e = exp_q.pop_front(); chk_cnt++;
            if ({16'h0, rd2_s} !== e) $display("FAIL small_rd2 a=%0d got=%h exp=%h", 7 - i, rd2_s, e); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_write_read();
        test_reg_zero();
        test_bypass();
        test_rd_reg();
        test_back_to_back();
        test_small_config();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
